ahblite_gpio_port: RTL and testbench
====================================

AHBLITE_GPIO_PORT -- requirements
Module: ahblite_gpio_port

Interface
REQ-001 Parameter WIDTH, default 8: GPIO pin count, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..3.
REQ-003 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 HRESETn  input  1  asynchronous active-low reset.
REQ-005 HSEL, HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HPROT[3:0], HWRITE, HWDATA[31:0], HREADY  inputs  AHB-Lite slave inputs.
REQ-006 HREADYOUT  output  1  tied 1.
REQ-007 HRESP  output  1  tied 0 (OKAY).
REQ-008 HRDATA  output  32  read data, valid in the data phase.
REQ-009 gpio_in  input  WIDTH  asynchronous pin inputs.
REQ-010 gpio_out  output  WIDTH  pin output values.
REQ-011 gpio_oe  output  WIDTH  per-pin output enable; 1 drives the pin.
REQ-012 irq  output  1  level interrupt, registered.

Function
REQ-013 Transfer accepted when HSEL & HREADY & HTRANS[1]; address and HWRITE captured at that edge.
REQ-014 Write data taken from HWDATA[WIDTH-1:0] in the data phase; register updated at the data-phase end; HSIZE and HPROT ignored.
REQ-015 Read: HRDATA muxed from the captured address during the data phase, so a read issued directly after a write to the same offset returns the new value.
REQ-016 Decode uses HADDR[7:2]; unmapped offsets read 0; writes to them are ignored.
REQ-017 Bits above WIDTH-1 read 0.
REQ-018 Map:
- 0x00 DATA_OUT RW
- 0x04 DIR RW (1 = output)
- 0x08 DATA_IN RO (synchronised value)
- 0x0C INT_EN RW
- 0x10 INT_POL RW (1 = rising, 0 = falling)
- 0x14 INT_BOTH RW (1 = both edges, overrides INT_POL)
- 0x18 INT_STAT R/W1C
- 0x1C OUT_SET W1S (reads 0)
- 0x20 OUT_CLR W1C (reads 0)
REQ-019 gpio_out = DATA_OUT; gpio_oe = DIR.
REQ-020 gpio_in passes a SYNC_STAGES-deep flop chain; DATA_IN is the last stage.
REQ-021 An edge is detected by comparing the last stage with one further delayed flop; detection latency from the pin change is SYNC_STAGES+1 cycles.
REQ-022 INT_STAT[i] sets on a qualifying edge only when INT_EN[i]=1; disabled pins never set status.
REQ-023 A W1C write clears the written-1 bits of INT_STAT; on the same bit in the same cycle as a new edge, the set wins.
REQ-024 irq is registered: irq <= |(INT_STAT & INT_EN), so it asserts one cycle after INT_STAT sets.
REQ-025 OUT_SET/OUT_CLR act as DATA_OUT |= wdata / DATA_OUT &= ~wdata in a single cycle; bits not written are unaffected.
REQ-026 Clearing INT_EN[i] masks irq but leaves INT_STAT[i] unchanged.

Reset
REQ-027 On HRESETn low, asynchronously clear: DATA_OUT, DIR, INT_EN, INT_POL, INT_BOTH, INT_STAT, all synchroniser and edge flops, irq, and the captured address/write state. Result: gpio_oe=0 (all pins inputs), HRDATA=0.
REQ-028 Reset asserted mid-transfer aborts it; no register is modified by the aborted write.
REQ-029 After deassertion, no edge is reported until the synchroniser has refilled (SYNC_STAGES+1 cycles).

Verification
REQ-030 Write 0xA5 to 0x00 and 0xFF to 0x04, then read 0x00 -> gpio_out=0xA5, gpio_oe=0xFF, HRDATA=0xA5 in the next data phase.
REQ-031 DATA_OUT=0x0F; write 0xF0 to 0x1C, then 0x03 to 0x20 -> DATA_OUT reads 0xFF, then 0xFC.
REQ-032 INT_EN=0x01, INT_POL=0x01; gpio_in[0] goes 0->1 -> INT_STAT=0x01 after 3 cycles and irq=1 after 4; write 0x01 to 0x18 -> INT_STAT=0, irq=0 next cycle.
REQ-033 INT_BOTH=0x02, INT_EN=0x02; toggle gpio_in[1] twice -> status sets on each edge; a W1C write coinciding with the second edge leaves INT_STAT[1]=1.
REQ-034 WIDTH=4 instance: write 0xFFFFFFFF to 0x00 -> reads 0x0000000F; read 0x3C -> 0.
REQ-035 Assert HRESETn low during the data phase of a write of 0x55 to 0x00 -> DATA_OUT=0, gpio_oe=0, irq=0 immediately and after release.

Source files
------------

// File: rtl/ahblite_gpio_port.sv
// AHB-Lite GPIO port: output/direction registers, synchronised pin inputs and
// per-pin edge-detect interrupts with write-one-to-clear status.
module ahblite_gpio_port #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             HSEL,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   input  logic [2:0]       HSIZE,
   input  logic [3:0]       HPROT,
   input  logic             HWRITE,
   input  logic [31:0]      HWDATA,
   input  logic             HREADY,
   output logic             HREADYOUT,
   output logic             HRESP,
   output logic [31:0]      HRDATA,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam int unsigned OFF_W       = 6;
   localparam int unsigned FILL_W      = 3;
   localparam int unsigned FILL_CYCLES = SYNC_STAGES + 1;

   localparam logic [OFF_W-1:0] OFF_DATA_OUT = 6'h00;
   localparam logic [OFF_W-1:0] OFF_DIR      = 6'h01;
   localparam logic [OFF_W-1:0] OFF_DATA_IN  = 6'h02;
   localparam logic [OFF_W-1:0] OFF_INT_EN   = 6'h03;
   localparam logic [OFF_W-1:0] OFF_INT_POL  = 6'h04;
   localparam logic [OFF_W-1:0] OFF_INT_BOTH = 6'h05;
   localparam logic [OFF_W-1:0] OFF_INT_STAT = 6'h06;
   localparam logic [OFF_W-1:0] OFF_OUT_SET  = 6'h07;
   localparam logic [OFF_W-1:0] OFF_OUT_CLR  = 6'h08;

   logic                                acc_q, acc_d;
   logic                                wr_q, wr_d;
   logic [OFF_W-1:0]                    addr_q, addr_d;
   logic [WIDTH-1:0]                    data_out_q, data_out_d;
   logic [WIDTH-1:0]                    dir_q, dir_d;
   logic [WIDTH-1:0]                    int_en_q, int_en_d;
   logic [WIDTH-1:0]                    int_pol_q, int_pol_d;
   logic [WIDTH-1:0]                    int_both_q, int_both_d;
   logic [WIDTH-1:0]                    int_stat_q, int_stat_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q, sync_d;
   logic [WIDTH-1:0]                    prev_q, prev_d;
   logic [FILL_W-1:0]                   fill_q, fill_d;
   logic                                irq_q, irq_d;

   logic [WIDTH-1:0] wdata, din, rise, fall, hit, w1c, rd_val;
   logic             accept, wr_en, armed;
   logic             unused_ok;

   assign unused_ok = ^{HSIZE, HPROT, HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA};

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign gpio_out  = data_out_q;
   assign gpio_oe   = dir_q;
   assign irq       = irq_q;

   always_comb begin
      acc_d      = acc_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      data_out_d = data_out_q;
      dir_d      = dir_q;
      int_en_d   = int_en_q;
      int_pol_d  = int_pol_q;
      int_both_d = int_both_q;
      int_stat_d = int_stat_q;
      fill_d     = fill_q;
      w1c        = '0;
      rd_val     = '0;
      HRDATA     = '0;

      // Address phase capture
      accept = HSEL & HREADY & HTRANS[1];
      acc_d  = accept;
      if (accept) begin
         wr_d   = HWRITE;
         addr_d = HADDR[7:2];
      end

      // Data phase write commit
      wdata = HWDATA[WIDTH-1:0];
      wr_en = acc_q & wr_q;
      if (wr_en) begin
         case (addr_q)
            OFF_DATA_OUT: data_out_d = wdata;
            OFF_DIR:      dir_d      = wdata;
            OFF_INT_EN:   int_en_d   = wdata;
            OFF_INT_POL:  int_pol_d  = wdata;
            OFF_INT_BOTH: int_both_d = wdata;
            OFF_INT_STAT: w1c        = wdata;
            OFF_OUT_SET:  data_out_d = data_out_q | wdata;
            OFF_OUT_CLR:  data_out_d = data_out_q & ~wdata;
            default:      ;
         endcase
      end

      // Synchroniser and edge detect, held off until the chain has refilled after reset
      sync_d = {sync_q[SYNC_STAGES-2:0], gpio_in};
      din    = sync_q[SYNC_STAGES-1];
      prev_d = din;
      armed  = (fill_q == FILL_W'(FILL_CYCLES));
      if (!armed) fill_d = fill_q + FILL_W'(1);

      rise = din & ~prev_q;
      fall = ~din & prev_q;
      hit  = int_en_q & ((int_both_q & (rise | fall)) |
                         (~int_both_q & ((int_pol_q & rise) | (~int_pol_q & fall))));
      if (!armed) hit = '0;

      // A new edge beats a simultaneous clear
      int_stat_d = (int_stat_q & ~w1c) | hit;
      irq_d      = |(int_stat_q & int_en_q);

      case (addr_q)
         OFF_DATA_OUT: rd_val = data_out_q;
         OFF_DIR:      rd_val = dir_q;
         OFF_DATA_IN:  rd_val = din;
         OFF_INT_EN:   rd_val = int_en_q;
         OFF_INT_POL:  rd_val = int_pol_q;
         OFF_INT_BOTH: rd_val = int_both_q;
         OFF_INT_STAT: rd_val = int_stat_q;
         default:      rd_val = '0;
      endcase
      if (acc_q & ~wr_q) HRDATA = 32'(rd_val);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         acc_q      <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_out_q <= '0;
         dir_q      <= '0;
         int_en_q   <= '0;
         int_pol_q  <= '0;
         int_both_q <= '0;
         int_stat_q <= '0;
         sync_q     <= '0;
         prev_q     <= '0;
         fill_q     <= '0;
         irq_q      <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         int_en_q   <= int_en_d;
         int_pol_q  <= int_pol_d;
         int_both_q <= int_both_d;
         int_stat_q <= int_stat_d;
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         fill_q     <= fill_d;
         irq_q      <= irq_d;
      end
   end

endmodule

// File: tb/tb_ahblite_gpio_port.sv
// Self-checking bench for ahblite_gpio_port: directed scenarios plus random
// bus/pin traffic checked against a cycle-level reference model.
module tb_ahblite_gpio_port;

   localparam int unsigned W = 8;
   localparam int unsigned S = 2;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL, HWRITE, HREADY;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic        HREADYOUT, HRESP, irq;
   logic [31:0] HRDATA;
   logic [W-1:0] gpio_in, gpio_out, gpio_oe;

   logic        HREADYOUT4, HRESP4, irq4;
   logic [31:0] HRDATA4;
   logic [3:0]  gpio_in4 = 4'h0;
   logic [3:0]  gpio_out4, gpio_oe4;

   int errors = 0;
   int checks = 0;

   always #5 HCLK = ~HCLK;

   ahblite_gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
   );

   ahblite_gpio_port #(.WIDTH(4), .SYNC_STAGES(S)) u_dut4 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT4), .HRESP(HRESP4), .HRDATA(HRDATA4),
      .gpio_in(gpio_in4), .gpio_out(gpio_out4), .gpio_oe(gpio_oe4), .irq(irq4)
   );

   // Reference model: register file plus a history of sampled pin values
   logic [W-1:0] m_out, m_dir, m_en, m_pol, m_both, m_stat;
   logic         m_irq, m_pend, m_pwr;
   logic [5:0]   m_paddr;
   logic [W-1:0] m_hist [0:S];
   int unsigned  m_since;

   always @(posedge HCLK or negedge HRESETn) begin : ref_model
      logic [W-1:0] nw, od, rise, fall, hit, wd, clr, t_out, t_dir, t_en, t_pol, t_both;
      if (!HRESETn) begin
         m_out <= '0; m_dir <= '0; m_en <= '0; m_pol <= '0; m_both <= '0; m_stat <= '0;
         m_irq <= 1'b0; m_pend <= 1'b0; m_pwr <= 1'b0; m_paddr <= '0; m_since <= 0;
         for (int i = 0; i <= S; i++) m_hist[i] <= '0;
      end else begin
         nw   = m_hist[S-1];
         od   = m_hist[S];
         rise = nw & ~od;
         fall = ~nw & od;
         hit  = '0;
         for (int i = 0; i < W; i++) begin
            if (m_en[i] && m_since >= S + 1) begin
               if (m_both[i])     hit[i] = rise[i] | fall[i];
               else if (m_pol[i]) hit[i] = rise[i];
               else               hit[i] = fall[i];
            end
         end
         t_out = m_out; t_dir = m_dir; t_en = m_en; t_pol = m_pol; t_both = m_both;
         clr = '0;
         wd  = HWDATA[W-1:0];
         if (m_pend && m_pwr) begin
            case (m_paddr)
               6'h00: t_out  = wd;
               6'h01: t_dir  = wd;
               6'h03: t_en   = wd;
               6'h04: t_pol  = wd;
               6'h05: t_both = wd;
               6'h06: clr    = wd;
               6'h07: t_out  = m_out | wd;
               6'h08: t_out  = m_out & ~wd;
               default: ;
            endcase
         end
         m_irq  <= |(m_stat & m_en);
         m_stat <= (m_stat & ~clr) | hit;
         m_out <= t_out; m_dir <= t_dir; m_en <= t_en; m_pol <= t_pol; m_both <= t_both;
         m_pend <= HSEL && HREADY && HTRANS[1];
         if (HSEL && HREADY && HTRANS[1]) begin
            m_paddr <= HADDR[7:2];
            m_pwr   <= HWRITE;
         end
         for (int i = S; i > 0; i--) m_hist[i] <= m_hist[i-1];
         m_hist[0] <= gpio_in;
         if (m_since < 100) m_since <= m_since + 1;
      end
   end

   function automatic logic [31:0] exp_read(input logic [5:0] off);
      case (off)
         6'h00:   return 32'(m_out);
         6'h01:   return 32'(m_dir);
         6'h02:   return 32'(m_hist[S-1]);
         6'h03:   return 32'(m_en);
         6'h04:   return 32'(m_pol);
         6'h05:   return 32'(m_both);
         6'h06:   return 32'(m_stat);
         default: return 32'h0;
      endcase
   endfunction

   task automatic bus_idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      @(negedge HCLK);
      bus_idle(); HWDATA = d;
      @(negedge HCLK);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] r8, output logic [31:0] r4);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      @(negedge HCLK);
      bus_idle();
      r8 = HRDATA; r4 = HRDATA4;
   endtask

   // Write immediately followed by a pipelined read of the same address
   task automatic bus_wr_rd(input logic [31:0] a, input logic [31:0] d, output logic [31:0] r8);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      @(negedge HCLK);
      HWDATA = d; HWRITE = 1'b0;
      @(negedge HCLK);
      bus_idle();
      r8 = HRDATA;
   endtask

   task automatic test_reset();
      checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL reset_oe: got %h expected 00", gpio_oe); end
      checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", gpio_out); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", HRDATA); end
      checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b/%b expected 1/0", HREADYOUT, HRESP); end
   endtask

   task automatic test_basic();
      logic [31:0] r8, r4;
      bus_write(32'h00, 32'hA5);
      bus_write(32'h04, 32'hFF);
      bus_read(32'h00, r8, r4);
      checks++; if (r8 !== 32'hA5) begin errors++; $display("FAIL basic_read: got %h expected a5", r8); end
      checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL basic_out: got %h expected a5", gpio_out); end
      checks++; if (gpio_oe !== 8'hFF) begin errors++; $display("FAIL basic_oe: got %h expected ff", gpio_oe); end
      @(negedge HCLK); gpio_in = 8'h5A;
      repeat (4) @(negedge HCLK);
      bus_read(32'h08, r8, r4);
      checks++; if (r8 !== 32'h5A) begin errors++; $display("FAIL data_in: got %h expected 5a", r8); end
      @(negedge HCLK); gpio_in = 8'h00;
      repeat (4) @(negedge HCLK);
   endtask

   task automatic test_set_clr();
      logic [31:0] r8, r4;
      bus_write(32'h00, 32'h0F);
      bus_write(32'h1C, 32'hF0);
      bus_read(32'h00, r8, r4);
      checks++; if (r8 !== 32'hFF) begin errors++; $display("FAIL out_set: got %h expected ff", r8); end
      bus_write(32'h20, 32'h03);
      bus_read(32'h00, r8, r4);
      checks++; if (r8 !== 32'hFC) begin errors++; $display("FAIL out_clr: got %h expected fc", r8); end
      bus_read(32'h1C, r8, r4);
      checks++; if (r8 !== 32'h0) begin errors++; $display("FAIL set_reads0: got %h expected 0", r8); end
      bus_read(32'h20, r8, r4);
      checks++; if (r8 !== 32'h0) begin errors++; $display("FAIL clr_reads0: got %h expected 0", r8); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r8;
      bus_wr_rd(32'h00, 32'h96, r8);
      checks++; if (r8 !== 32'h96) begin errors++; $display("FAIL b2b_out: got %h expected 96", r8); end
      bus_wr_rd(32'h10, 32'h3C, r8);
      checks++; if (r8 !== 32'h3C) begin errors++; $display("FAIL b2b_pol: got %h expected 3c", r8); end
      bus_write(32'h10, 32'h00);
   endtask

   task automatic test_width4();
      logic [31:0] r8, r4;
      bus_write(32'h00, 32'hFFFFFFFF);
      bus_read(32'h00, r8, r4);
      checks++; if (r4 !== 32'h0000000F) begin errors++; $display("FAIL w4_read: got %h expected 0000000f", r4); end
      checks++; if (r8 !== 32'h000000FF) begin errors++; $display("FAIL w8_upper: got %h expected 000000ff", r8); end
      bus_read(32'h3C, r8, r4);
      checks++; if (r4 !== 32'h0 || r8 !== 32'h0) begin errors++; $display("FAIL unmapped: got %h/%h expected 0/0", r8, r4); end
      bus_write(32'h24, 32'hFF);
      bus_read(32'h24, r8, r4);
      checks++; if (r8 !== 32'h0) begin errors++; $display("FAIL unmapped_wr: got %h expected 0", r8); end
   endtask

   task automatic test_irq_rise();
      logic [31:0] r8, r4;
      bus_write(32'h0C, 32'h01);
      bus_write(32'h10, 32'h01);
      @(negedge HCLK); gpio_in[0] = 1'b1;
      @(negedge HCLK);
      @(negedge HCLK);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early1: got %b expected 0", irq); end
      @(negedge HCLK);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early2: got %b expected 0", irq); end
      @(negedge HCLK);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
      bus_read(32'h18, r8, r4);
      checks++; if (r8 !== 32'h01) begin errors++; $display("FAIL stat_rise: got %h expected 01", r8); end
      bus_write(32'h18, 32'h01);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", irq); end
      @(negedge HCLK);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
      bus_read(32'h18, r8, r4);
      checks++; if (r8 !== 32'h0) begin errors++; $display("FAIL stat_w1c: got %h expected 0", r8); end
   endtask

   task automatic test_both_w1c();
      logic [31:0] r8, r4;
      bus_write(32'h0C, 32'h02);
      bus_write(32'h14, 32'h02);
      @(negedge HCLK); gpio_in[1] = 1'b1;
      repeat (4) @(negedge HCLK);
      bus_read(32'h18, r8, r4);
      checks++; if (r8 !== 32'h02) begin errors++; $display("FAIL both_rise: got %h expected 02", r8); end
      bus_write(32'h18, 32'h02);
      bus_read(32'h18, r8, r4);
      checks++; if (r8 !== 32'h0) begin errors++; $display("FAIL both_clr: got %h expected 0", r8); end
      // Second (falling) edge lands on the same edge as the W1C commit
      @(negedge HCLK); gpio_in[1] = 1'b0;
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h18;
      @(negedge HCLK);
      bus_idle(); HWDATA = 32'h02;
      @(negedge HCLK);
      bus_read(32'h18, r8, r4);
      checks++; if (r8 !== 32'h02) begin errors++; $display("FAIL set_wins: got %h expected 02", r8); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL both_irq: got %b expected 1", irq); end
      bus_write(32'h0C, 32'h00);
      @(negedge HCLK);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL en_mask: got %b expected 0", irq); end
      bus_read(32'h18, r8, r4);
      checks++; if (r8 !== 32'h02) begin errors++; $display("FAIL mask_keeps_stat: got %h expected 02", r8); end
   endtask

   task automatic test_random();
      logic [31:0] r8, r4, rnd, a, exp;
      int unsigned op, off;
      for (int k = 0; k < 250; k++) begin
         op  = $urandom_range(0, 3);
         off = $urandom_range(0, 10);
         if (off == 10) off = 15;
         rnd = $urandom;
         a   = {rnd[31:8], 6'(off), 2'b00};
         case (op)
            0: begin @(negedge HCLK); gpio_in = W'($urandom); end
            1: bus_write(a, $urandom);
            2: begin
               bus_read(a, r8, r4);
               exp = exp_read(6'(off));
               checks++; if (r8 !== exp) begin errors++; $display("FAIL rnd_read off=%0h: got %h expected %h", off, r8, exp); end
            end
            default: begin
               bus_wr_rd(a, $urandom, r8);
               exp = exp_read(6'(off));
               checks++; if (r8 !== exp) begin errors++; $display("FAIL rnd_b2b off=%0h: got %h expected %h", off, r8, exp); end
            end
         endcase
         checks++; if (gpio_out !== m_out) begin errors++; $display("FAIL rnd_out: got %h expected %h", gpio_out, m_out); end
         checks++; if (gpio_oe !== m_dir) begin errors++; $display("FAIL rnd_oe: got %h expected %h", gpio_oe, m_dir); end
         checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq: got %b expected %b", irq, m_irq); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r8, r4;
      bus_write(32'h04, 32'hFF);
      bus_write(32'h00, 32'h3C);
      bus_write(32'h0C, 32'hFF);
      bus_write(32'h14, 32'hFF);
      @(negedge HCLK); gpio_in[0] = ~gpio_in[0];
      repeat (5) @(negedge HCLK);
      checks++; if (irq !== 1'b1 || gpio_out !== 8'h3C || gpio_oe !== 8'hFF) begin
         errors++; $display("FAIL pre_reset: got irq=%b out=%h oe=%h expected 1/3c/ff", irq, gpio_out, gpio_oe); end
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
      @(negedge HCLK);
      bus_idle(); HWDATA = 32'h55;
      HRESETn = 1'b0;
      #1;
      checks++; if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || irq !== 1'b0 || HRDATA !== 32'h0) begin
         errors++; $display("FAIL reset_now: got out=%h oe=%h irq=%b rd=%h expected 0", gpio_out, gpio_oe, irq, HRDATA); end
      @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (6) @(negedge HCLK);
      checks++; if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || irq !== 1'b0) begin
         errors++; $display("FAIL reset_after: got out=%h oe=%h irq=%b expected 0", gpio_out, gpio_oe, irq); end
      bus_read(32'h00, r8, r4);
      checks++; if (r8 !== 32'h0) begin errors++; $display("FAIL aborted_write: got %h expected 0", r8); end
   endtask

   initial begin
      HRESETn = 1'b1;
      HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010; HPROT = 4'h3;
      HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1; gpio_in = '0;
      #1 HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      test_reset();
      HRESETn = 1'b1;
      repeat (5) @(negedge HCLK);
      test_basic();
      test_set_clr();
      test_back_to_back();
      test_width4();
      test_irq_rise();
      test_both_w1c();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
